// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage iterative divider: op encodings,
// FSM states and the RV32M special-case result constants.
package ex_div_unit_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [XLEN_DEF-1:0] DIV0_QUOTIENT = '1;
    localparam logic [XLEN_DEF-1:0] INT_MIN       = {1'b1, {(XLEN_DEF-1){1'b0}}};

    // op[0] set means the unsigned variant (DIVU/REMU)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_div_unit_div_iter_core.sv
// One combinational restoring-division step: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_iter_core
    import ex_div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            take;

    always_comb begin
        shifted = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        // rem_in stays below the divisor, so its top bit only matters defensively
        take    = rem_in[XLEN] | ~trial[XLEN+1];
        if (take) begin
            rem_out = trial[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted;
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |divisor| > |dividend|.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic            sgn_op, a_neg, b_neg, div0, ovf, early_out;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   core_rem;
    logic [XLEN-1:0] core_quo, q_fix, r_fix;

    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
        return XLEN'(0) - v;
    endfunction

    div_iter_core #(.XLEN(XLEN)) u_core (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (core_rem),
        .quo_out (core_quo)
    );

    always_comb begin
        sgn_op = op_is_signed(op);
        a_neg  = sgn_op & rs1_val[XLEN-1];
        b_neg  = sgn_op & rs2_val[XLEN-1];
        a_mag  = a_neg ? neg2c(rs1_val) : rs1_val;
        b_mag  = b_neg ? neg2c(rs2_val) : rs2_val;
        div0   = (rs2_val == '0);
        ovf    = sgn_op && (rs1_val == XLEN'(INT_MIN)) && (rs2_val == '1);
`ifdef DIV_EARLY_OUT_EN
        early_out = (b_mag > a_mag);
`else
        early_out = 1'b0;
`endif
        q_fix  = quo_neg_q ? neg2c(core_quo) : core_quo;
        r_fix  = rem_neg_q ? neg2c(core_rem[XLEN-1:0]) : core_rem[XLEN-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        op_d      = op_q;
        rd_d      = rd_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    rd_d      = rd_in;
                    quo_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dvsr_d    = b_mag;
                    quo_d     = a_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    // Special cases resolve here; the remainder for div-by-zero and
                    // early-out is the original dividend, the quotient a constant.
                    if (div0 || ovf || early_out) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        rd_out_d = rd_in;
                        if (div0)
                            result_d = op[1] ? rs1_val : XLEN'(DIV0_QUOTIENT);
                        else if (ovf)
                            result_d = op[1] ? '0 : XLEN'(INT_MIN);
                        else
                            result_d = op[1] ? rs1_val : '0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = core_rem;
                    quo_d = core_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = op_q[1] ? r_fix : q_fix;
                        rd_out_d = rd_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign stall_req = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
    assign done      = done_q;
    assign result    = result_q;
    assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed table-driven bench for ex_div_unit plus flush/reset sequences.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op_i;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_i;
    logic        stall_req, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    ex_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op_i),
        .rs1_val   (rs1),
        .rs2_val   (rs2),
        .rd_in     (rd_i),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called mid-cycle (at a negedge): the current cycle is cycle 0.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic [31:0] res,
                          output logic [4:0] rdo, output int stalls, output logic pulse_ok);
        int cyc;
        lat = -1; res = '0; rdo = '0; stalls = 0; pulse_ok = 1'b0;
        start = 1'b1; op_i = o; rs1 = a; rs2 = b; rd_i = rd;
        #1;
        stalls = int'(stall_req);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= 80 && lat < 0) begin
            if (done) begin
                lat = cyc; res = result; rdo = rd_out;
            end else begin
                stalls += int'(stall_req);
                @(negedge clk);
                cyc++;
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            pulse_ok = !done;
        end
    endtask

    initial begin
        int          lat, stalls;
        logic [31:0] res, prev_res;
        logic [4:0]  rdo, prev_rd;
        logic        pok, saw_done;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{2'b00, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{2'b10, 32'h0000_1234,  32'd0,          32'h0000_1234,  1};
        vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[8]  = '{2'b01, 32'd3,          32'd10,         32'd0,          EO_LAT};
        vecs[9]  = '{2'b11, 32'd3,          32'd10,         32'd3,          EO_LAT};
        vecs[10] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[11] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33};
        vecs[12] = '{2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          33};
        vecs[13] = '{2'b10, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  33};
        vecs[14] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[15] = '{2'b10, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  EO_LAT};
        vecs[16] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          EO_LAT};
        vecs[17] = '{2'b00, 32'd5,          32'hFFFF_FFF6,  32'd0,          EO_LAT};
        vecs[18] = '{2'b01, 32'd0,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[19] = '{2'b11, 32'd0,          32'd0,          32'd0,          1};
        vecs[20] = '{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  33};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op_i = '0; rs1 = '0; rs2 = '0; rd_i = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",  32'(busy),      32'd0);
        check("reset_done",  32'(done),      32'd0);
        check("reset_result", result,        32'd0);
        check("reset_rd",    32'(rd_out),    32'd0);
        check("reset_stall", 32'(stall_req), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), lat, res, rdo, stalls, pok);
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_rd", i), 32'(rdo), 32'(i + 1));
            check($sformatf("v%0d_stall_cycles", i), 32'(stalls), 32'(vecs[i].lat));
            check($sformatf("v%0d_done_single", i), 32'(pok), 32'd1);
        end

        // flush together with start in IDLE: start is ignored
        start = 1'b1; flush = 1'b1; op_i = 2'b01; rs1 = 32'd50; rs2 = 32'd5; rd_i = 5'd30;
        #1;
        check("flush_start_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        check("flush_start_done", 32'(done), 32'd0);

        // flush mid-CALC at cycle 10, restart at cycle 12
        prev_res = result; prev_rd = rd_out; saw_done = 1'b0;
        start = 1'b1; op_i = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; rd_i = 5'd20;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            saw_done |= done;
            @(negedge clk);
        end
        saw_done |= done;
        check("flush_busy_c10", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        saw_done |= done;
        check("flush_busy_c11", 32'(busy), 32'd0);
        check("flush_rd_kept", 32'(rd_out), 32'(prev_rd));
        check("flush_result_kept", result, prev_res);
        @(negedge clk);
        saw_done |= done;
        check("flush_no_done", 32'(saw_done), 32'd0);
        run_op(2'b01, 32'd9, 32'd3, 5'd9, lat, res, rdo, stalls, pok);
        check("restart_done_cycle", 32'(lat + 12), 32'd45);
        check("restart_result", res, 32'd3);
        check("restart_rd", 32'(rdo), 32'd9);

        // reset in the middle of CALC
        start = 1'b1; op_i = 2'b00; rs1 = 32'd77; rs2 = 32'd4; rd_i = 5'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_rd", 32'(rd_out), 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (done) begin
                check("rst_mid_stray_done", 32'(done), 32'd0);
                break;
            end
        end
        check("rst_mid_idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
- Operands arrive already forwarded, downstream of the EX operand-forwarding muxes.
- Raises stall_req to freeze IF/ID/EX while it computes, then presents a one-cycle result to the EX/MEM register.
- Its rd_out/done feed MEM_rd/MEM_RegWrite, which drive the forwarding logic.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > XLEN

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  divide op valid in EX this cycle
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_val  input  XLEN  dividend (post-forwarding)
rs2_val  input  XLEN  divisor (post-forwarding)
rd_in  input  5  destination register
flush  input  1  kill in-flight op (branch/trap)
stall_req  output  1  hold upstream stages
busy  output  1  state != IDLE
done  output  1  result valid, one cycle
result  output  XLEN  quotient or remainder per op
rd_out  output  5  destination of completed op

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - busy=0, done=0, result=0, rd_out=0, counter=0.
  - Internal regs cleared.
  - rst overrides flush and start.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start & !flush: latch op, rd_in, |rs1|/|rs2| magnitudes (signed ops) or raw values (unsigned ops), and the sign flags.
  - divisor==0: go to DONE. Quotient = all ones; remainder = rs1_val.
  - Signed op with rs1=0x80000000 and rs2=0xFFFFFFFF: go to DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise: go to CALC with counter=0.
- CALC:
  - One restoring step per cycle: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - Exactly XLEN cycles. When counter==XLEN-1, go to DONE.
- DONE (one cycle):
  - done=1.
  - result = quotient (op[1]=0) or remainder (op[1]=1).
  - Signed fix-up: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Next state is IDLE.
- Outputs are registered in DONE: result and rd_out hold their value until the next DONE; done is a single-cycle pulse.
- stall_req = (IDLE & start & !flush) | CALC. It is 0 in DONE so the pipeline advances and the EX/MEM register captures the result in that cycle.
- Latency, normal path: start at cycle 0, done at cycle XLEN+1 (33). Special cases: done at cycle 1.
- flush in any non-IDLE state: go to IDLE next cycle, no done pulse; result/rd_out unchanged. flush together with start in IDLE: start is ignored.
- start while busy: ignored (pipeline is stalled, so start is held; a new op is accepted only in IDLE).
- Width rules: remainder register is XLEN+1 bits for the trial subtract. Negation is two's complement modulo 2^XLEN.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if unsigned-magnitude divisor > dividend (and divisor != 0), go directly to DONE with quotient=0 and remainder=dividend (sign fix-up still applied); latency 1.
- Undefined: such operands take the full XLEN-cycle CALC path. Results are identical either way; only latency differs.

Decomposition:
- Shared package holds:
  - op encodings (DIV/DIVU/REM/REMU).
  - state enum {IDLE, CALC, DONE}.
  - XLEN default.
  - constants DIV0_QUOTIENT and INT_MIN.
- One sub-module, div_iter_core: combinational restoring step (inputs rem, quo, divisor; outputs next rem and quo), instantiated once.

Test Plan:
- DIVU rs1=100, rs2=7 -> stall_req high for 33 cycles, done at cycle 33, result=14; REMU with the same operands -> result=2.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> result=0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
- DIV rs2=0, rs1=0x1234 -> done at cycle 1, result=0xFFFFFFFF; REM with the same operands -> 0x1234.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> done at cycle 1, result=0x80000000; REM with the same operands -> 0.
- DIVU 1000/3, flush asserted at cycle 10 -> busy=0 at cycle 11, no done pulse, rd_out unchanged. A new DIVU 9/3 started at cycle 12 -> done at cycle 45, result=3.
- rst asserted mid-CALC -> next cycle busy=0, done=0, result=0. With DIV_EARLY_OUT_EN, DIVU 3/10 -> done at cycle 1, result=0.
